// File: rtl/vga_pkg.sv
// Shared definitions for the VGA image path.
// Holds the default widths and row stride used by both the display-side
// address counter and the write-side image writer, plus the state type of
// the writer FSM.
package vga_pkg;

    localparam int ADDR_W_DEF = 18;   // image RAM address width
    localparam int DATA_W_DEF = 8;    // pixel width
    localparam int DIM_W_DEF  = 10;   // window dimension width
    localparam int STRIDE_DEF = 512;  // address distance between image rows

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/contador_ventana.sv
// Window position counter for the image writer.
// Tracks the current column (x), row (y) and the RAM address of the start of
// the current row (row_base). Produces the address of the current pixel and
// a flag that is high while the counter points at the last pixel of the
// window.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous active-high reset, clears all counters
//   load        latch base/width/height and rewind to pixel (0,0)
//   advance     step to the next pixel in raster order
//   base        address of window pixel (0,0)
//   width       pixels per row
//   height      number of rows
//   pixel_addr  (row_base + x) mod 2^ADDR_W
//   last_pixel  high when x == width-1 and y == height-1
module contador_ventana
    import vga_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DIM_W  = DIM_W_DEF,
    parameter int STRIDE = STRIDE_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              advance,
    input  logic [ADDR_W-1:0] base,
    input  logic [DIM_W-1:0]  width,
    input  logic [DIM_W-1:0]  height,
    output logic [ADDR_W-1:0] pixel_addr,
    output logic              last_pixel
);

    logic [DIM_W-1:0]  x;
    logic [DIM_W-1:0]  y;
    logic [DIM_W-1:0]  width_q;
    logic [DIM_W-1:0]  height_q;
    logic [ADDR_W-1:0] row_base;
    logic              end_of_row;

    assign end_of_row = (x == width_q - DIM_W'(1));
    assign last_pixel = end_of_row && (y == height_q - DIM_W'(1));
    // Natural ADDR_W-bit overflow gives the wrap at the top of memory.
    assign pixel_addr = row_base + ADDR_W'(x);

    always_ff @(posedge clk) begin
        if (reset) begin
            x        <= '0;
            y        <= '0;
            row_base <= '0;
            width_q  <= '0;
            height_q <= '0;
        end else if (load) begin
            x        <= '0;
            y        <= '0;
            row_base <= base;
            width_q  <= width;
            height_q <= height;
        end else if (advance) begin
            if (end_of_row) begin
                x        <= '0;
                y        <= y + DIM_W'(1);
                row_base <= row_base + ADDR_W'(STRIDE);
            end else begin
                x <= x + DIM_W'(1);
            end
        end
    end

endmodule

// File: rtl/escritor_imagen.sv
// Image writer: takes the processor pixel stream and writes a rectangular
// window into the write port of the dual-port image RAM read by the VGA
// controller.
//
// Ports:
//   clock_25    pixel clock, all logic on the rising edge
//   reset       synchronous active-high reset
//   start       request a window write (only looked at in IDLE)
//   base_addr   address of window pixel (0,0), latched on accepted start
//   win_width   pixels per row, latched on accepted start
//   win_height  number of rows, latched on accepted start
//   s_valid     stream pixel valid
//   s_data      stream pixel value
//   s_ready     block accepts a pixel this cycle
//   we          RAM write enable
//   address     RAM write address
//   data_wram   RAM write data
//   busy        window write in progress
//   done        one-cycle pulse when the window is complete
//
// Stream handshake: a pixel moves only in a cycle where s_valid and s_ready
// are both high. s_ready depends on the FSM state alone (never on s_valid),
// and s_valid/s_data are ignored whenever s_ready is low. Each accepted pixel
// appears on we/address/data_wram exactly one cycle later.
module escritor_imagen
    import vga_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int STRIDE = STRIDE_DEF,
    parameter int DIM_W  = DIM_W_DEF
) (
    input  logic              clock_25,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [DIM_W-1:0]  win_width,
    input  logic [DIM_W-1:0]  win_height,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              we,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data_wram,
    output logic              busy,
    output logic              done
);

    state_t            state;
    state_t            state_next;
    logic              load;
    logic              transfer;
    logic              dims_ok;
    logic              last_pixel;
    logic [ADDR_W-1:0] pixel_addr;

    assign dims_ok  = (win_width != '0) && (win_height != '0);
    assign transfer = s_valid && s_ready;

    contador_ventana #(
        .ADDR_W (ADDR_W),
        .DIM_W  (DIM_W),
        .STRIDE (STRIDE)
    ) u_contador (
        .clk        (clock_25),
        .reset      (reset),
        .load       (load),
        .advance    (transfer),
        .base       (base_addr),
        .width      (win_width),
        .height     (win_height),
        .pixel_addr (pixel_addr),
        .last_pixel (last_pixel)
    );

    always_ff @(posedge clock_25) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        s_ready    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (dims_ok) begin
                        load       = 1'b1;
                        state_next = WRITE;
                    end else begin
                        // Empty window: report completion without writing.
                        state_next = DONE;
                    end
                end
            end
            WRITE: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                if (s_valid && last_pixel) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                // The registered write of the last pixel is on the bus now.
                busy       = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // One-cycle write pipeline; address/data hold between writes.
    always_ff @(posedge clock_25) begin
        if (reset) begin
            we        <= 1'b0;
            address   <= '0;
            data_wram <= '0;
        end else begin
            we <= transfer;
            if (transfer) begin
                address   <= pixel_addr;
                data_wram <= s_data;
            end
        end
    end

endmodule

// File: doc/escritor_imagen.md
Name: escritor_imagen

Overview:
- Write-side counterpart of the VGA display path: takes a pixel stream from the processor datapath and writes it into the image RAM that the VGA controller reads.
- Writes a rectangular window of win_width x win_height pixels, starting at base_addr, with a fixed row stride.
- Generates RAM write strobes, addresses and data, and reports busy/done to the control logic.
- Sits between the processor stream output and the write port of the dual-port image RAM.

Parameters:
- ADDR_W, 18, width of the image RAM address.
- DATA_W, 8, pixel width.
- STRIDE, 512, address distance between two consecutive image rows.
- DIM_W, 10, width of the window dimension inputs.

Ports:
- clock_25  in  1  system pixel clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a window write; sampled only in IDLE.
- base_addr  in  ADDR_W  address of window pixel (0,0); latched on an accepted start.
- win_width  in  DIM_W  pixels per row; latched on an accepted start.
- win_height  in  DIM_W  number of rows; latched on an accepted start.
- s_valid  in  1  stream pixel valid.
- s_data  in  DATA_W  stream pixel value.
- s_ready  out  1  block can accept a pixel this cycle.
- we  out  1  RAM write enable.
- address  out  ADDR_W  RAM write address.
- data_wram  out  DATA_W  RAM write data.
- busy  out  1  high while a window write is in progress.
- done  out  1  one-cycle pulse when the window is complete.

Behaviour:
- Reset state: FSM in IDLE; we=0, address=0, data_wram=0, s_ready=0, busy=0, done=0; x, y and row_base counters cleared.
- Reset mid-frame: FSM returns to IDLE on the next edge. No further we is produced, no done pulse is produced, and the partial frame is abandoned.
- FSM states: IDLE, WRITE, FLUSH, DONE.
- IDLE:
  - start=1 with both dimensions nonzero: latch the inputs, set x=0, y=0, row_base=base_addr, go to WRITE.
  - start=1 with either dimension zero: go to DONE; no write is produced.
- WRITE:
  - busy=1. s_ready=1 is combinational from state==WRITE.
  - A transfer happens when s_valid and s_ready are both 1.
  - On a transfer at cycle T, at T+1: we=1, address=(row_base+x) mod 2^ADDR_W, data_wram=s_data. Latency is one cycle.
  - In any cycle after WRITE entry with no transfer, we=0 the next cycle. address and data_wram hold their last values.
  - Counter update on a transfer: if x==win_width-1 then x=0, y=y+1, row_base=(row_base+STRIDE) mod 2^ADDR_W; otherwise x=x+1.
  - Transfer of the last pixel (x==win_width-1 and y==win_height-1): go to FLUSH; s_ready=0 from T+1.
- FLUSH: one cycle in which the final we=1 is presented, then go to DONE.
- DONE: done=1 and busy=0 for exactly one cycle, then go to IDLE.
  - Timing for a last transfer at cycle T: final we at T+1, done at T+2.
- start outside IDLE is ignored. The latched dimensions and base are unaffected.
- Address arithmetic is modulo 2^ADDR_W, so a window crossing the top of memory wraps to 0.
- x and y comparisons use DIM_W bits; row_base uses ADDR_W bits.
- s_data and s_valid are don't-care whenever s_ready=0.

Decomposition:
- Shared package vga_pkg holds:
  - ADDR_W and DATA_W defaults,
  - the FSM state enum typedef (IDLE, WRITE, FLUSH, DONE),
  - the STRIDE default, shared with the VGA address counter.
- One sub-module, contador_ventana, holds the x, y and row_base counters, the computed pixel address, and the last-pixel flag.
  - Its inputs are load, advance, base, width and height.
  - The top-level module contains the FSM and the output registers.

Test Plan:
- 2x2 window, base=0, STRIDE=512, s_valid held high, pixels 0x11, 0x22, 0x33, 0x44 -> writes (0,0x11), (1,0x22), (512,0x33), (513,0x44) on 4 consecutive cycles; done two cycles after the last accept; busy low in the done cycle.
- 3x1 window at base=100 with s_valid toggling 1,0,1,0,1 -> exactly 3 we pulses at addresses 100, 101, 102, each one cycle after its accept; we=0 in gap cycles.
- win_width=0, win_height=5, start -> no we ever; done pulse one cycle after start; busy never high.
- Wrap: base=0x3FFFF, 2x2 window, STRIDE=512 -> addresses 0x3FFFF, 0x00000, 0x001FF, 0x00200.
- Reset asserted after 3 of 6 pixels of a 3x2 window -> we=0 and busy=0 from the next cycle; no done pulse; a new start then writes from its own base.
- start pulsed with new base=7 during WRITE of a base=0 window -> ignored; all addresses follow base=0; done occurs only once.
